// File: rtl/avalon_st_pkg.sv
// avalon_st_pkg: shared types and constants for the packet arbiter.
package avalon_st_pkg;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   // Last-served index after reset; N-1 gives input 0 first priority.
   function automatic int arb_last_init(input int n);
      return n - 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request searching cyclically from last+1.
module rr_priority_pick #(
   parameter  int N  = 4,
   localparam int CW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [CW-1:0] last,
   output logic [CW-1:0] pick,
   output logic          any
);

   logic [N-1:0] rot;

   always_comb begin
      // Doubling the vector lets a plain shift act as a rotate by last+1.
      rot  = N'({req, req} >> (int'(last) + 1));
      any  = |req;
      pick = '0;
      for (int i = N - 1; i >= 0; i--)
         if (rot[i]) pick = CW'((int'(last) + 1 + i) % N);
   end

endmodule

// File: rtl/packet_arbiter_avalon_st.sv
// packet_arbiter_avalon_st: packet-locked round-robin merge of N Avalon-ST
// sources onto one registered sink, tagging each beat with its source index.
module packet_arbiter_avalon_st
   import avalon_st_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int N     = 4,
   localparam int CW    = $clog2(N)
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic [N-1:0]              in_ready,
   input  logic [N-1:0]              in_valid,
   input  logic [N-1:0][WIDTH-1:0]   in_data,
   input  logic [N-1:0]              in_startofpacket,
   input  logic [N-1:0]              in_endofpacket,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_startofpacket,
   output logic                      out_endofpacket,
   output logic [CW-1:0]             out_channel
);

   localparam logic [CW-1:0] ARB_LAST_INIT = CW'(arb_last_init(N));

   arb_state_t       state_q;
   logic [CW-1:0]    grant_q, last_q, pick;
   logic             any, accept;
   logic             out_valid_q, out_sop_q, out_eop_q;
   logic [WIDTH-1:0] out_data_q;
   logic [CW-1:0]    out_channel_q;

   rr_priority_pick #(.N(N)) u_pick (
      .req  (in_valid),
      .last (last_q),
      .pick (pick),
      .any  (any)
   );

   always_comb begin
      in_ready = '0;
      if (state_q == LOCKED) in_ready[grant_q] = !out_valid_q || out_ready;
      accept = in_valid[grant_q] && in_ready[grant_q];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         last_q        <= ARB_LAST_INIT;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_sop_q     <= 1'b0;
         out_eop_q     <= 1'b0;
         out_channel_q <= '0;
      end else begin
         if (state_q == IDLE && any) begin
            grant_q <= pick;
            state_q <= LOCKED;
         end
         if (accept) begin
            out_valid_q   <= 1'b1;
            out_data_q    <= in_data[grant_q];
            out_sop_q     <= in_startofpacket[grant_q];
            out_eop_q     <= in_endofpacket[grant_q];
            out_channel_q <= grant_q;
            if (in_endofpacket[grant_q]) begin
               last_q  <= grant_q;
               state_q <= IDLE;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid         = out_valid_q;
   assign out_data          = out_data_q;
   assign out_startofpacket = out_sop_q;
   assign out_endofpacket   = out_eop_q;
   assign out_channel       = out_channel_q;

endmodule

// File: tb/tb_packet_arbiter_avalon_st.sv
// tb_packet_arbiter_avalon_st: directed and random checks of the packet arbiter
// against a cycle-level behavioural model with per-source packet queues.
module tb_packet_arbiter_avalon_st;

   localparam int N = 4;
   localparam int W = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [N-1:0]        in_ready, in_valid, in_sop, in_eop;
   logic [N-1:0][W-1:0] in_data;
   logic                out_ready, out_valid, out_sop, out_eop;
   logic [W-1:0]        out_data;
   logic [1:0]          out_channel;

   packet_arbiter_avalon_st #(.WIDTH(W), .N(N)) dut (
      .clock             (clock),
      .reset             (reset),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_channel       (out_channel)
   );

   int total = 0;
   int bad   = 0;

   logic [N-1:0]   en;
   logic [W+1:0]   pk[N][256];
   int             hd[N], tl[N];

   int             m_owner, m_last;
   logic           m_ov, m_os, m_oe;
   logic [W-1:0]   m_od;
   logic [1:0]     m_oc;

   int             log_d[$], log_c[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ld(input int i);
      return i < log_d.size() ? log_d[i] : -1;
   endfunction

   function automatic int lc(input int i);
      return i < log_c.size() ? log_c[i] : -1;
   endfunction

   task automatic push_pkt(input int src, input int len, input int base);
      for (int b = 0; b < len; b++) begin
         pk[src][tl[src] & 255] = {b == 0, b == len - 1, W'(base + b)};
         tl[src]++;
      end
   endtask

   function automatic logic [N-1:0] m_ready();
      logic [N-1:0] r;
      r = '0;
      if (m_owner >= 0) r[m_owner] = !m_ov || out_ready;
      return r;
   endfunction

   task automatic drive();
      logic [W+1:0] b;
      for (int i = 0; i < N; i++) begin
         b = pk[i][hd[i] & 255];
         in_valid[i] = en[i] && (hd[i] != tl[i]);
         {in_sop[i], in_eop[i], in_data[i]} = b;
      end
   endtask

   // Spec-level behaviour: a source owns the sink from grant through its EOP beat;
   // grants go to the next valid source cyclically after the last one served.
   task automatic model_step();
      logic [N-1:0] r;
      int own;
      bit acc;
      r = m_ready();
      if (reset) begin
         m_owner = -1; m_last = N - 1;
         m_ov = 0; m_od = '0; m_os = 0; m_oe = 0; m_oc = '0;
         return;
      end
      own = m_owner;
      acc = own >= 0 && in_valid[own] && r[own];
      if (own < 0)
         for (int k = 1; k <= N; k++)
            if (in_valid[(m_last + k) % N]) begin m_owner = (m_last + k) % N; break; end
      if (acc) begin
         m_ov = 1; m_od = in_data[own]; m_os = in_sop[own]; m_oe = in_eop[own]; m_oc = 2'(own);
         hd[own]++;
         if (in_eop[own]) begin m_last = own; m_owner = -1; end
      end else if (out_ready) begin
         m_ov = 0;
      end
   endtask

   task automatic cyc();
      drive();
      @(negedge clock);
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
         chk("out_data", 32'(out_data), 32'(m_od));
         chk("out_sop", 32'(out_sop), 32'(m_os));
         chk("out_eop", 32'(out_eop), 32'(m_oe));
         chk("out_channel", 32'(out_channel), 32'(m_oc));
      end
      if (out_valid === 1'b1 && out_ready) begin
         log_d.push_back(int'(out_data));
         log_c.push_back(int'(out_channel));
      end
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      log_d.delete();
      log_c.delete();
   endtask

   initial begin
      out_ready = 1'b1;
      en = '0;
      in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
      for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
      m_owner = -1; m_last = N - 1;
      m_ov = 0; m_od = '0; m_os = 0; m_oe = 0; m_oc = '0;
      run(2);
      do_reset();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_chan", 32'(out_channel), 0);
      chk("rst_ready", 32'(in_ready), 0);

      // 3-beat packet on source 0
      push_pkt(0, 3, 'hA1);
      en = 4'b0001;
      run(8);
      chk("t1_len", log_d.size(), 3);
      chk("t1_d0", ld(0), 'hA1);
      chk("t1_d1", ld(1), 'hA2);
      chk("t1_d2", ld(2), 'hA3);
      chk("t1_c", lc(2), 0);

      // all four sources, 2-beat packets, source 0 twice
      do_reset();
      for (int i = 0; i < N; i++) push_pkt(i, 2, 'h10 * (i + 1));
      push_pkt(0, 2, 'h50);
      en = 4'b1111;
      run(20);
      chk("t2_len", log_c.size(), 10);
      for (int p = 0; p < 5; p++) begin
         chk("t2_order", lc(2 * p), p % N);
         chk("t2_nointerleave", lc(2 * p + 1), lc(2 * p));
      end

      // backpressure mid-packet on source 2
      do_reset();
      push_pkt(2, 4, 'h30);
      en = 4'b0100;
      run(3);
      out_ready = 1'b0;
      run(3);
      out_ready = 1'b1;
      run(6);
      chk("t3_len", log_d.size(), 4);
      for (int b = 0; b < 4; b++) chk("t3_data", ld(b), 'h30 + b);

      // single-beat packets alternating between sources 1 and 3
      do_reset();
      push_pkt(1, 1, 'h41); push_pkt(1, 1, 'h42);
      push_pkt(3, 1, 'h43); push_pkt(3, 1, 'h44);
      en = 4'b1010;
      run(12);
      chk("t4_len", log_c.size(), 4);
      chk("t4_c0", lc(0), 1);
      chk("t4_c1", lc(1), 3);
      chk("t4_c2", lc(2), 1);
      chk("t4_c3", lc(3), 3);

      // source 0 stalls mid-packet while source 1 waits
      do_reset();
      push_pkt(0, 4, 'h80);
      push_pkt(1, 2, 'h90);
      en = 4'b0011;
      run(3);
      en = 4'b0010;
      run(5);
      en = 4'b0011;
      run(12);
      chk("t5_len", log_c.size(), 6);
      for (int b = 0; b < 4; b++) chk("t5_src0", lc(b), 0);
      chk("t5_src1", lc(4), 1);

      // reset during beat 2 of a 4-beat packet on source 2
      do_reset();
      push_pkt(2, 4, 'h60);
      en = 4'b0100;
      run(2);
      push_pkt(1, 2, 'h70);
      en = 4'b0110;
      do_reset();
      chk("t6_valid", 32'(out_valid), 0);
      chk("t6_data", 32'(out_data), 0);
      chk("t6_chan", 32'(out_channel), 0);
      run(8);
      chk("t6_next", lc(0), 1);
      chk("t6_nd", ld(0), 'h70);

      // random traffic, backpressure and occasional reset
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++)
            if (tl[i] - hd[i] < 6) push_pkt(i, $urandom_range(1, 4), $urandom_range(0, 255));
         en = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 99) == 0);
         cyc();
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
